// File: rtl/jlsemi_util_cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC blocks: FSM encoding and
// the legal depth range of the bit synchronizers.
package jlsemi_util_cdc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hs_state_e;

    localparam int SYNC_STEP_MIN = 2;
    localparam int SYNC_STEP_MAX = 3;

    function automatic bit sync_step_legal(input int n);
        return (n >= SYNC_STEP_MIN) && (n <= SYNC_STEP_MAX);
    endfunction

endpackage

// File: rtl/jlsemi_util_sync_pos_with_rst_high.sv
// Multi-flop bit synchronizer, rising edge, synchronous active-high reset.
// Under JL_SYNTHESIS the chain is kept intact for the synchronizer cell flow.
module jlsemi_util_sync_pos_with_rst_high #(
    parameter int SYNC_STEP = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

`ifdef JL_SYNTHESIS
    (* dont_touch = "true", async_reg = "true" *) logic [SYNC_STEP-1:0] sync_q;
`else
    logic [SYNC_STEP-1:0] sync_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STEP-2:0], din};
        end
    end

    assign dout = sync_q[SYNC_STEP-1];

endmodule

// File: rtl/jlsemi_util_cdc_hs_tx.sv
// Source half of a two-phase request/acknowledge bus crossing: captures a word,
// toggles req_tgl, and waits for the synchronized ack level to match it.
module jlsemi_util_cdc_hs_tx
    import jlsemi_util_cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STEP   = 2,
    parameter int TIMEOUT_CYC = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              src_vld,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_rdy,
    output logic              xfer_done,
    output logic              req_tgl,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              ack_tgl_async,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam bit               TO_EN    = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LAST  = TO_LIMIT - CNT_W'(1);

    if (!sync_step_legal(SYNC_STEP)) begin : g_bad_sync_step
        $error("jlsemi_util_cdc_hs_tx: SYNC_STEP out of range");
    end

    hs_state_e        state;
    logic             ack_sync;
    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;

    jlsemi_util_sync_pos_with_rst_high #(
        .SYNC_STEP (SYNC_STEP)
    ) u_ack_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ack_tgl_async),
        .dout (ack_sync)
    );

    assign src_rdy = (state == ST_IDLE);
    assign to_hit  = TO_EN && (state == ST_BUSY) && (to_cnt == TO_LAST);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_tgl     <= 1'b0;
            xfer_data   <= '0;
            xfer_done   <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (src_vld) begin
                        xfer_data <= src_data;
                        req_tgl   <= ~req_tgl;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (TO_EN && (to_cnt != TO_LIMIT)) begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                    // Level compare: matched ack means the destination holds this word.
                    if (ack_sync == req_tgl) begin
                        state     <= ST_IDLE;
                        xfer_done <= 1'b1;
                        to_cnt    <= '0;
                    end
                end
            endcase
            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jlsemi_util_cdc_hs_tx.sv
// Directed bench for jlsemi_util_cdc_hs_tx with a transaction-level reference
// model compared every cycle, plus literal expectations per scenario.
module tb_jlsemi_util_cdc_hs_tx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STEP   = 2;
    localparam int TIMEOUT_CYC = 10;
    localparam int CNT_W       = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              src_vld = 1'b0;
    logic [DATA_W-1:0] src_data = '0;
    logic              src_rdy;
    logic              xfer_done;
    logic              req_tgl;
    logic [DATA_W-1:0] xfer_data;
    logic              ack_tgl_async;
    logic              timeout_err;
    logic              err_clr = 1'b0;

    logic man_ack   = 1'b0;
    logic dest_ack  = 1'b0;
    logic dest_auto = 1'b0;
    int   dest_dly  = 0;

    assign ack_tgl_async = dest_auto ? dest_ack : man_ack;

    always #5 clk = ~clk;

    jlsemi_util_cdc_hs_tx #(
        .DATA_W      (DATA_W),
        .SYNC_STEP   (SYNC_STEP),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_vld       (src_vld),
        .src_data      (src_data),
        .src_rdy       (src_rdy),
        .xfer_done     (xfer_done),
        .req_tgl       (req_tgl),
        .xfer_data     (xfer_data),
        .ack_tgl_async (ack_tgl_async),
        .timeout_err   (timeout_err),
        .err_clr       (err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the destination's ack is seen SYNC_STEP edges late; a
    // transfer ends on the first edge where that delayed level equals the request.
    bit              m_on = 1'b0;
    logic            m_busy, m_req, m_done, m_err;
    logic [DATA_W-1:0] m_data;
    int              m_cycles;
    logic            ack_hist [SYNC_STEP];

    always @(posedge clk) begin : model
        logic ack_seen;
        bit   set_err;
        if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_req = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_data = '0; m_cycles = 0;
            for (int i = 0; i < SYNC_STEP; i++) ack_hist[i] = 1'b0;
        end else if (m_on) begin
            ack_seen = ack_hist[SYNC_STEP-1];
            for (int i = SYNC_STEP - 1; i > 0; i--) ack_hist[i] = ack_hist[i-1];
            ack_hist[0] = ack_tgl_async;
            m_done  = 1'b0;
            set_err = 1'b0;
            if (m_busy) begin
                m_cycles++;
                set_err = (TIMEOUT_CYC > 0) && (m_cycles == TIMEOUT_CYC);
                if (ack_seen == m_req) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (src_vld) begin
                m_busy   = 1'b1;
                m_req    = ~m_req;
                m_data   = src_data;
                m_cycles = 0;
            end
            if (set_err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            check("model src_rdy", src_rdy, !m_busy);
            check("model xfer_done", xfer_done, m_done);
            check("model req_tgl", req_tgl, m_req);
            check("model xfer_data", xfer_data, m_data);
            check("model timeout_err", timeout_err, m_err);
        end
    end

    // Destination stand-in: echoes the request level four cycles after it changes.
    always @(negedge clk) begin
        if (!dest_auto) begin
            dest_ack = man_ack;
            dest_dly = 0;
        end else if (req_tgl != dest_ack) begin
            dest_dly++;
            if (dest_dly == 4) begin
                dest_ack = req_tgl;
                dest_dly = 0;
            end
        end else begin
            dest_dly = 0;
        end
    end

    int   req_changes = 0;
    int   done_cnt    = 0;
    logic req_prev    = 1'b0;
    always @(negedge clk) begin
        if (req_tgl !== req_prev) req_changes++;
        req_prev = req_tgl;
        if (xfer_done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_rdy(input string name);
        for (int k = 0; k < 50 && src_rdy !== 1'b1; k++) @(negedge clk);
        check(name, src_rdy, 1'b1);
    endtask

    task automatic accept(input logic [DATA_W-1:0] d);
        src_vld  = 1'b1;
        src_data = d;
        tick();
        src_vld  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:2] reqs;
        int         base;

        // Reset state
        tick(2);
        check("rst src_rdy", src_rdy, 1'b1);
        check("rst req_tgl", req_tgl, 1'b0);
        check("rst xfer_data", xfer_data, 8'h00);
        check("rst xfer_done", xfer_done, 1'b0);
        check("rst timeout_err", timeout_err, 1'b0);
        rst = 1'b0;

        // 1: single word; ack after edge 3 -> done pulse after edge 6
        tick();
        accept(8'hA5);
        check("t1 req_tgl", req_tgl, 1'b1);
        check("t1 xfer_data", xfer_data, 8'hA5);
        check("t1 src_rdy busy", src_rdy, 1'b0);
        tick(2);
        man_ack = 1'b1;
        tick(2);
        check("t1 no early done", xfer_done, 1'b0);
        check("t1 still busy", src_rdy, 1'b0);
        tick();
        check("t1 done pulse", xfer_done, 1'b1);
        check("t1 src_rdy back", src_rdy, 1'b1);
        tick();
        check("t1 done one cycle", xfer_done, 1'b0);

        // 2: throttled back-to-back words against the auto-acking destination
        rst = 1'b1; man_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        base = req_changes;
        dest_auto = 1'b1;
        src_vld = 1'b1;
        src_data = 8'd1;
        for (int w = 1; w <= 3; w++) begin
            wait_rdy("t2 rdy before accept");
            tick();
            reqs[w-1] = req_tgl;
            src_data = DATA_W'(w + 1);
        end
        wait_rdy("t2 rdy after last");
        src_vld = 1'b0;
        tick(20);
        check("t2 req seq 1", reqs[0], 1'b1);
        check("t2 req seq 2", reqs[1], 1'b0);
        check("t2 req seq 3", reqs[2], 1'b1);
        check("t2 accept count", req_changes - base, 3);
        check("t2 last word", xfer_data, 8'd3);

        // 3: spurious ack activity while idle
        man_ack = 1'b1;
        dest_auto = 1'b0;
        tick(2);
        base = done_cnt;
        man_ack = 1'b0;
        tick(5);
        man_ack = 1'b1;
        tick(5);
        check("t3 no spurious done", done_cnt - base, 0);
        check("t3 idle kept", src_rdy, 1'b1);
        check("t3 req kept", req_tgl, 1'b1);
        accept(8'h3C);
        check("t3 req new", req_tgl, 1'b0);
        tick(5);
        check("t3 waits for match", src_rdy, 1'b0);
        man_ack = 1'b0;
        tick(2);
        check("t3 done not yet", xfer_done, 1'b0);
        tick();
        check("t3 done on match", xfer_done, 1'b1);

        // 4: timeout after 10 BUSY cycles, sticky through completion
        accept(8'h77);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("t4 no early timeout", timeout_err, 1'b0);
        end
        tick();
        check("t4 timeout set", timeout_err, 1'b1);
        tick(5);
        check("t4 timeout sticky", timeout_err, 1'b1);
        check("t4 still busy", src_rdy, 1'b0);
        man_ack = 1'b1;
        tick(3);
        check("t4 late done", xfer_done, 1'b1);
        check("t4 idle", src_rdy, 1'b1);
        check("t4 err kept", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4 err cleared", timeout_err, 1'b0);

        // 6: err_clr on the threshold edge -> set wins
        accept(8'h11);
        tick(9);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6 set wins", timeout_err, 1'b1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6 clear", timeout_err, 1'b0);
        man_ack = 1'b0;
        wait_rdy("t6 completes");

        // 5: reset mid-transfer
        accept(8'hC3);
        check("t5 busy req", req_tgl, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 src_rdy", src_rdy, 1'b1);
        check("t5 req_tgl", req_tgl, 1'b0);
        check("t5 xfer_data", xfer_data, 8'h00);
        check("t5 xfer_done", xfer_done, 1'b0);
        accept(8'h5A);
        check("t5 next word", xfer_data, 8'h5A);
        man_ack = 1'b1;
        wait_rdy("t5 next completes");
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
